// File: rtl/bug_pkg.sv
// Shared constants, state encoding and edge-bounce helper for the bug sprite motion controller.
package bug_pkg;

  localparam int SCREEN_WIDTH  = 1024;
  localparam int SCREEN_HEIGHT = 768;
  localparam int PIC_WIDTH     = 54;
  localparam int PIC_HEIGHT    = 53;
  localparam int MAX_X         = SCREEN_WIDTH - PIC_WIDTH;
  localparam int MAX_Y         = SCREEN_HEIGHT - PIC_HEIGHT;
  localparam int STEP_MAX      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_e;

  // Returns {new_dir_down, new_pos}; dirDown=0 means moving towards maxPos.
  function automatic logic [12:0] bounce(input logic [11:0] pos, input logic dirDown,
                                         input logic [4:0] step, input logic [11:0] maxPos);
    logic [12:0] sum;
    logic [12:0] res;
    sum = {1'b0, pos} + {8'd0, step};
    if (!dirDown)
      res = (sum >= {1'b0, maxPos}) ? {1'b1, maxPos} : {1'b0, sum[11:0]};
    else
      res = ({1'b0, pos} <= {8'd0, step}) ? 13'd0 : {1'b1, pos - {7'd0, step}};
    return res;
  endfunction

endpackage

// File: rtl/bug_motion_ctrl_edge_rise.sv
// One-bit rising-edge detector; history resets high so a level held through reset release is not an edge.
module edge_rise (
  input  logic pclk,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) prev_q <= 1'b1;
    else        prev_q <= sig_i;
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/bug_motion_ctrl.sv
// Frame-synchronous bug sprite motion controller (IDLE/RUN/PAUSE, bounce at screen edges).
// Optional macro BUG_SPEEDUP_EN: step grows by one every 256 moves, saturating at STEP_MAX.
module bug_motion_ctrl
  import bug_pkg::*;
#(
  parameter int unsigned STEP      = 2,
  parameter int unsigned FRAME_DIV = 1,
  parameter int unsigned X_INIT    = 485,
  parameter int unsigned Y_INIT    = 358
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        vblnk_in,
  input  logic        start_btn,
  input  logic        pause_btn,
  output logic [11:0] x_bugpos,
  output logic [11:0] y_bugpos,
  output logic [1:0]  state_out,
  output logic        frame_tick
);

  logic        tick, startRise, pauseRise;
  state_e      state_q;
  logic [11:0] xPos_q, yPos_q;
  logic        dirX_q, dirY_q;
  logic [7:0]  divCnt_q;
  logic        frameTick_q;
  logic [4:0]  step;
  logic [12:0] xBounce_d, yBounce_d;
  logic        doMove;

  edge_rise uVblnk (.pclk(pclk), .reset(reset), .sig_i(vblnk_in),  .rise_o(tick));
  edge_rise uStart (.pclk(pclk), .reset(reset), .sig_i(start_btn), .rise_o(startRise));
  edge_rise uPause (.pclk(pclk), .reset(reset), .sig_i(pause_btn), .rise_o(pauseRise));

`ifdef BUG_SPEEDUP_EN
  logic [4:0] step_q;
  logic [7:0] moveCnt_q;
  assign step = step_q;
`else
  assign step = 5'(STEP);
`endif

  assign xBounce_d = bounce(xPos_q, dirX_q, step, 12'(MAX_X));
  assign yBounce_d = bounce(yPos_q, dirY_q, step, 12'(MAX_Y));
  assign doMove    = (state_q == ST_RUN) && tick && (divCnt_q == 8'(FRAME_DIV - 1));

  // A restart (start in RUN/PAUSE) is written last so it overrides a coincident move.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      xPos_q      <= 12'(X_INIT);
      yPos_q      <= 12'(Y_INIT);
      dirX_q      <= 1'b0;
      dirY_q      <= 1'b0;
      divCnt_q    <= 8'd0;
      frameTick_q <= 1'b0;
`ifdef BUG_SPEEDUP_EN
      step_q      <= 5'(STEP);
      moveCnt_q   <= 8'd0;
`endif
    end else begin
      frameTick_q <= tick;
      if (state_q == ST_RUN && tick)
        divCnt_q <= doMove ? 8'd0 : divCnt_q + 8'd1;
      if (doMove) begin
        {dirX_q, xPos_q} <= xBounce_d;
        {dirY_q, yPos_q} <= yBounce_d;
`ifdef BUG_SPEEDUP_EN
        moveCnt_q <= moveCnt_q + 8'd1;
        if (moveCnt_q == 8'hFF && step_q < 5'(STEP_MAX))
          step_q <= step_q + 5'd1;
`endif
      end
      case (state_q)
        ST_IDLE: begin
          if (startRise) state_q <= ST_RUN;
`ifdef BUG_SPEEDUP_EN
          step_q    <= 5'(STEP);
          moveCnt_q <= 8'd0;
`endif
        end
        ST_RUN, ST_PAUSE: begin
          if (startRise) begin
            state_q  <= ST_IDLE;
            xPos_q   <= 12'(X_INIT);
            yPos_q   <= 12'(Y_INIT);
            dirX_q   <= 1'b0;
            dirY_q   <= 1'b0;
            divCnt_q <= 8'd0;
          end else if (pauseRise) begin
            state_q <= (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign x_bugpos   = xPos_q;
  assign y_bugpos   = yPos_q;
  assign state_out  = state_q;
  assign frame_tick = frameTick_q;

endmodule

// File: tb/tb_bug_motion_ctrl.sv
// Self-checking bench for bug_motion_ctrl: two instances (FRAME_DIV 1 and 3) against a behavioural model.
module tb_bug_motion_ctrl;

  logic        pclk = 1'b0;
  logic        reset;
  logic        vblnk_in, start_btn, pause_btn;
  logic [11:0] x0, y0, x3, y3;
  logic [1:0]  s0, s3;
  logic        ft0, ft3;

  int checks = 0;
  int errors = 0;

  // Model state, index 0 = FRAME_DIV 1, index 1 = FRAME_DIV 3; dirs are +1/-1.
  int mState[2], mX[2], mY[2], mDx[2], mDy[2], mDiv[2], mFt[2], mStep[2], mMoves[2];
  int frameDiv[2] = '{1, 3};
  int prevV, prevS, prevP;

  bug_motion_ctrl #(.STEP(2), .FRAME_DIV(1)) dut1 (
    .pclk(pclk), .reset(reset), .vblnk_in(vblnk_in), .start_btn(start_btn), .pause_btn(pause_btn),
    .x_bugpos(x0), .y_bugpos(y0), .state_out(s0), .frame_tick(ft0));

  bug_motion_ctrl #(.STEP(2), .FRAME_DIV(3)) dut3 (
    .pclk(pclk), .reset(reset), .vblnk_in(vblnk_in), .start_btn(start_btn), .pause_btn(pause_btn),
    .x_bugpos(x3), .y_bugpos(y3), .state_out(s3), .frame_tick(ft3));

  // Free-running pixel clock
  always #5 pclk = ~pclk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", tag, $time, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mState[i] = 0; mX[i] = 485; mY[i] = 358; mDx[i] = 1; mDy[i] = 1;
      mDiv[i] = 0; mFt[i] = 0; mStep[i] = 2; mMoves[i] = 0;
    end
    prevV = 1; prevS = 1; prevP = 1;
  endtask

  task automatic moveAxis(inout int pos, inout int dir, input int step, input int maxv);
    if (dir > 0) begin
      if (pos + step >= maxv) begin pos = maxv; dir = -1; end
      else pos = pos + step;
    end else begin
      if (pos <= step) begin pos = 0; dir = 1; end
      else pos = pos - step;
    end
  endtask

  // One clock edge of the model using the inputs about to be sampled
  task automatic modelClock();
    int tk, sr, pr, cur;
    tk = (vblnk_in && prevV == 0) ? 1 : 0;
    sr = (start_btn && prevS == 0) ? 1 : 0;
    pr = (pause_btn && prevP == 0) ? 1 : 0;
    for (int i = 0; i < 2; i++) begin
      cur = mState[i];
      mFt[i] = tk;
      if (cur == 1 && tk == 1) begin
        mDiv[i]++;
        if (mDiv[i] == frameDiv[i]) begin
          mDiv[i] = 0;
          moveAxis(mX[i], mDx[i], mStep[i], 1024 - 54);
          moveAxis(mY[i], mDy[i], mStep[i], 768 - 53);
`ifdef BUG_SPEEDUP_EN
          mMoves[i]++;
          if (mMoves[i] % 256 == 0 && mStep[i] < 16) mStep[i]++;
`endif
        end
      end
      if (sr == 1) begin
        if (cur == 0) mState[i] = 1;
        else begin
          mState[i] = 0; mX[i] = 485; mY[i] = 358; mDx[i] = 1; mDy[i] = 1; mDiv[i] = 0;
          mStep[i] = 2; mMoves[i] = 0;
        end
      end else if (pr == 1) begin
        if (cur == 1) mState[i] = 2;
        else if (cur == 2) mState[i] = 1;
      end
    end
    prevV = vblnk_in; prevS = start_btn; prevP = pause_btn;
  endtask

  task automatic checkAll();
    checkOutput("x_div1", x0, mX[0]);
    checkOutput("y_div1", y0, mY[0]);
    checkOutput("state_div1", s0, mState[0]);
    checkOutput("tick_div1", ft0, mFt[0]);
    checkOutput("x_div3", x3, mX[1]);
    checkOutput("y_div3", y3, mY[1]);
    checkOutput("state_div3", s3, mState[1]);
    checkOutput("tick_div3", ft3, mFt[1]);
  endtask

  // Check the previous cycle's result at the falling edge, then drive the next inputs
  task automatic applyStimulus(input logic rstN, input logic v, input logic s, input logic p);
    @(negedge pclk);
    checkAll();
    reset = rstN; vblnk_in = v; start_btn = s; pause_btn = p;
    if (!rstN) modelReset();
    else modelClock();
  endtask

  task automatic runFrame();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Directed scenarios first, then a long randomized run
  initial begin
    int vCnt, vLen, vHigh;
    logic v, s, p, r;
    reset = 1'b0; vblnk_in = 1'b0; start_btn = 1'b0; pause_btn = 1'b0;
    modelReset();

    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'(i % 2), 1'b0, 1'b0);
    checkOutput("reset_x", x0, 485);
    checkOutput("reset_y", y0, 358);
    checkOutput("reset_state", s0, 0);
    checkOutput("reset_tick", ft0, 0);

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("release_no_tick", ft0, 0);

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("start_run", s0, 1);

    for (int i = 0; i < 3; i++) runFrame();
    checkOutput("three_moves_x", x0, 491);
    checkOutput("three_moves_y", y0, 364);
    checkOutput("div3_one_move_x", x3, 487);
    checkOutput("div3_one_move_y", y3, 360);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("pause_state", s0, 2);
    for (int i = 0; i < 5; i++) runFrame();
    checkOutput("paused_x", x0, 491);
    checkOutput("paused_state", s0, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("resume_state", s0, 1);
    runFrame();
    checkOutput("resume_x", x0, 493);

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("start_wins_state", s0, 0);
    checkOutput("start_wins_x", x0, 485);
    checkOutput("start_wins_y", y0, 358);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runFrame();
    checkOutput("restart_dir_x", x0, 487);
    checkOutput("restart_dir_y", y0, 360);

    vCnt = 0; vLen = 6; vHigh = 2;
    for (int c = 0; c < 40000; c++) begin
      v = (vCnt < vHigh);
      vCnt++;
      if (vCnt == vLen) begin
        vCnt = 0;
        vLen = $urandom_range(4, 9);
        vHigh = $urandom_range(1, 3);
      end
      if (mState[0] == 0) s = ($urandom_range(0, 19) == 0);
      else s = ($urandom_range(0, 5999) == 0);
      p = ($urandom_range(0, 1499) == 0);
      r = ($urandom_range(0, 14999) != 0);
      applyStimulus(r, v, s, p);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
